lap_store: RTL and testbench

//  Lap-time storage responder for the stopwatch/timer controller. Captures the running time on the

---
 rtl/stopwatch_pkg.sv | 8 +
 rtl/edge_pulse.sv | 20 ++
 rtl/lap_store.sv | 93 +++++++++
 tb/tb_lap_store.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and sizing, used by the controller, time counter and lap store.
package stopwatch_pkg;
  localparam int LAP_DEPTH = 8;
  localparam int TIME_W    = 16;

  typedef logic [TIME_W-1:0]            time_t;
  typedef logic [$clog2(LAP_DEPTH)-1:0] lap_ptr_t;
endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level input is high.
module edge_pulse (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic pls
);
  logic din_q_r;

  // previous-cycle copy of the level, updated every cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      din_q_r <= 1'b0;
    end else begin
      din_q_r <= din;
    end
  end

  assign pls = din & ~din_q_r;
endmodule

// File: rtl/lap_store.sv
// Lap-time ring buffer: saves time_in on a write edge, presents stored laps
// newest-to-oldest (wrapping) on successive read edges.
module lap_store import stopwatch_pkg::*; #(
  parameter int DEPTH  = LAP_DEPTH,
  parameter int TIME_W = stopwatch_pkg::TIME_W
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       clear,
  input  logic                       write,
  input  logic                       read,
  input  logic [TIME_W-1:0]          time_in,
  output logic [TIME_W-1:0]          lap_out,
  output logic [$clog2(DEPTH)-1:0]   lap_idx,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       valid,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              w_pls_s;
  logic              r_pls_s;
  logic [TIME_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  cursor_r;
  logic [CNT_W-1:0]  count_r;
  logic [TIME_W-1:0] lap_out_r;
  logic [PTR_W-1:0]  lap_idx_r;
  logic              valid_r;
  logic [PTR_W-1:0]  rd_addr_s;
  logic              cursor_last_s;

  edge_pulse u_write_edge (.clk(clk), .nrst(nrst), .din(write), .pls(w_pls_s));
  edge_pulse u_read_edge  (.clk(clk), .nrst(nrst), .din(read),  .pls(r_pls_s));

  // age 0 sits just behind the write pointer; older laps further back
  always_comb begin
    rd_addr_s     = wr_ptr_r - PTR_W'(1) - cursor_r;
    cursor_last_s = ({1'b0, cursor_r} == (count_r - CNT_W'(1)));
  end

  // storage array, written only on an accepted save (not reset)
  always_ff @(posedge clk) begin
    if (!clear && w_pls_s) begin
      mem_r[wr_ptr_r] <= time_in;
    end
  end

  // control state: clear beats write, write beats read
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r  <= '0;
      count_r   <= '0;
      cursor_r  <= '0;
      lap_out_r <= '0;
      lap_idx_r <= '0;
      valid_r   <= 1'b0;
    end else if (clear) begin
      wr_ptr_r  <= '0;
      count_r   <= '0;
      cursor_r  <= '0;
      lap_out_r <= '0;
      lap_idx_r <= '0;
      valid_r   <= 1'b0;
    end else if (w_pls_s) begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (count_r != CNT_W'(DEPTH)) begin
        count_r <= count_r + CNT_W'(1);
      end
      cursor_r <= '0;
      valid_r  <= 1'b0;
    end else if (r_pls_s) begin
      if (count_r == CNT_W'(0)) begin
        lap_out_r <= '0;
        valid_r   <= 1'b0;
      end else begin
        lap_out_r <= mem_r[rd_addr_s];
        lap_idx_r <= cursor_r;
        valid_r   <= 1'b1;
        cursor_r  <= cursor_last_s ? PTR_W'(0) : cursor_r + PTR_W'(1);
      end
    end
  end

  assign lap_out = lap_out_r;
  assign lap_idx = lap_idx_r;
  assign valid   = valid_r;
  assign count   = count_r;
  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == CNT_W'(0));
endmodule

// File: tb/tb_lap_store.sv
// Bench for lap_store: a lap-history model (newest-first list) checked against the DUT
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_lap_store;
  localparam int DEPTH = 8;

  logic        clk;
  logic        nrst;
  logic        clear;
  logic        write;
  logic        read;
  logic [15:0] time_in;
  logic [15:0] lap_out;
  logic [2:0]  lap_idx;
  logic [3:0]  count;
  logic        valid;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model: saved laps newest first, presentation cursor by age
  logic [15:0] hist[$];
  int          m_cur;
  logic [15:0] m_lap;
  int          m_idx;
  bit          m_valid;
  bit          m_wq;
  bit          m_rq;

  lap_store dut (
    .clk(clk), .nrst(nrst), .clear(clear), .write(write), .read(read),
    .time_in(time_in), .lap_out(lap_out), .lap_idx(lap_idx), .count(count),
    .valid(valid), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_cur   = 0;
    m_lap   = 16'd0;
    m_idx   = 0;
    m_valid = 1'b0;
    m_wq    = 1'b0;
    m_rq    = 1'b0;
  endtask

  task automatic model_step(input bit w, input bit r, input bit c, input logic [15:0] t);
    bit wp;
    bit rp;
    wp   = w && !m_wq;
    rp   = r && !m_rq;
    m_wq = w;
    m_rq = r;
    if (c) begin
      hist.delete();
      m_cur   = 0;
      m_lap   = 16'd0;
      m_idx   = 0;
      m_valid = 1'b0;
    end else if (wp) begin
      hist.push_front(t);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      m_cur   = 0;
      m_valid = 1'b0;
    end else if (rp) begin
      if (hist.size() == 0) begin
        m_lap   = 16'd0;
        m_valid = 1'b0;
      end else begin
        m_lap   = hist[m_cur];
        m_idx   = m_cur;
        m_valid = 1'b1;
        m_cur   = (m_cur + 1) % hist.size();
      end
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en && nrst) begin
      chk("count", count, hist.size());
      chk("full", full, hist.size() == DEPTH);
      chk("empty", empty, hist.size() == 0);
      chk("valid", valid, m_valid);
      chk("lap_out", lap_out, m_lap);
      chk("lap_idx", lap_idx, m_idx);
    end
  end

  // one clock: drive at negedge, advance model at posedge, return at next negedge
  task automatic cyc(input bit w, input bit r, input bit c, input logic [15:0] t);
    write   = w;
    read    = r;
    clear   = c;
    time_in = t;
    @(posedge clk);
    model_step(w, r, c, t);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] t);
    cyc(1'b1, 1'b0, 1'b0, t);
    cyc(1'b0, 1'b0, 1'b0, t);
  endtask

  task automatic do_read();
    cyc(1'b0, 1'b1, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    int exp_v;
    nrst = 1'b0; clear = 1'b0; write = 1'b0; read = 1'b0; time_in = 16'd0;
    model_reset();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    chk_en = 1'b1;

    // 1: reset state, read while empty
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_valid", valid, 0);
    do_read();
    chk("t1_valid", valid, 0);
    chk("t1_lap", lap_out, 0);

    // 2: three laps, four reads wrap to newest
    do_write(16'd100); do_write(16'd200); do_write(16'd300);
    for (int i = 0; i < 4; i++) begin
      do_read();
      exp_v = (i == 0 || i == 3) ? 300 : (i == 1 ? 200 : 100);
      chk("t2_lap", lap_out, exp_v);
      chk("t2_idx", lap_idx, (i == 3) ? 0 : i);
      chk("t2_valid", valid, 1);
    end
    chk("t2_count", count, 3);

    // 3: overfill wraps the ring
    cyc(1'b0, 1'b0, 1'b1, 16'd0);
    for (int i = 1; i <= 10; i++) do_write(16'(i));
    chk("t3_full", full, 1);
    chk("t3_count", count, 8);
    for (int i = 0; i < 9; i++) begin
      do_read();
      chk("t3_lap", lap_out, (i == 8) ? 10 : 10 - i);
    end

    // 4: held levels act once
    cyc(1'b0, 1'b0, 1'b1, 16'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 16'd42);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("t4_count", count, 1);
    do_write(16'd43);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("t4_lap_hold", lap_out, 43);
    do_read();
    chk("t4_lap_next", lap_out, 42);
    chk("t4_idx_next", lap_idx, 1);

    // 5: clear beats write, then write beats read
    cyc(1'b1, 1'b0, 1'b1, 16'd77);
    chk("t5_clr_count", count, 0);
    chk("t5_clr_valid", valid, 0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b1, 1'b0, 16'd88);
    chk("t5_wr_count", count, 1);
    chk("t5_wr_valid", valid, 0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);

    // 6: asynchronous reset mid-cycle
    cyc(1'b0, 1'b0, 1'b1, 16'd0);
    for (int i = 0; i < 5; i++) do_write(16'(500 + i));
    do_read();
    chk("t6_pre_valid", valid, 1);
    chk("t6_pre_count", count, 5);
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_lap", lap_out, 0);
    chk("t6_rst_empty", empty, 1);
    @(negedge clk);
    nrst = 1'b1;
    do_read();
    chk("t6_post_valid", valid, 0);

    // randomized traffic checked every cycle by the compare process
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 60) == 0), 16'($urandom));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
